// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension sequencer: func3 encodings, FSM states, divider iteration count.
package muldiv_sequencer_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_ITERS  = 32;
  localparam int ITER_CNT_W = 6;
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  // DIV and REM are the signed divide ops (func3[0] clear).
  function automatic logic is_signed_div(input logic [1:0] f3_lo);
    return !f3_lo[0];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per step, 32 steps after init.
// quo_next/rem_next expose the step result so the caller can capture the final values on the last step.
module muldiv_div_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0]       quo;
  logic [XLEN-1:0]       rem;
  logic [XLEN-1:0]       dvs;
  logic [ITER_CNT_W-1:0] cnt;
  logic [XLEN:0]         shifted;
  logic [XLEN:0]         diff;
  logic                  fits;

  // rem < divisor always holds, so the shifted partial remainder fits in XLEN+1 bits
  // and the top bit of the difference acts as the borrow.
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign fits     = !diff[XLEN];
  assign rem_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], fits};
  assign last     = (cnt == LAST_ITER);

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (init) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: MUL ops done at t+2, DIV ops at t+33; stall_req holds IF/ID/EX until DONE.
// MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the divider and finish at t+1.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic div_special(input logic [1:0] op_lo, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    return (b == '0) || (is_signed_div(op_lo) && (a == MOST_NEG) && (b == '1));
  endfunction

  function automatic logic [XLEN-1:0] div_special_res(input logic [1:0] op_lo,
                                                      input logic [XLEN-1:0] a,
                                                      input logic [XLEN-1:0] b);
    if (b == '0) return op_lo[1] ? a : '1;
    return op_lo[1] ? '0 : MOST_NEG;
  endfunction

  state_t          state, state_next;
  logic [1:0]      op;
  logic [XLEN-1:0] opa, opb;
  logic            accept;
  logic            in_neg1, in_neg2, neg1, neg2;
  logic [XLEN-1:0] dividend_mag, divisor_mag;
  logic            div_last;
  logic [XLEN-1:0] quo_raw, rem_raw, quo_fix, rem_fix, div_res;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  logic [XLEN-1:0] mul_res;

  assign accept = (state == IDLE) && start && !flush;

  // Magnitudes are taken from the live operands so the divider loads on the accept edge.
  assign in_neg1      = is_signed_div(func3[1:0]) && src1[XLEN-1];
  assign in_neg2      = is_signed_div(func3[1:0]) && src2[XLEN-1];
  assign dividend_mag = in_neg1 ? -src1 : src1;
  assign divisor_mag  = in_neg2 ? -src2 : src2;

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .init     (accept && func3[2]),
    .step     (state == DIV),
    .dividend (dividend_mag),
    .divisor  (divisor_mag),
    .last     (div_last),
    .quo_next (quo_raw),
    .rem_next (rem_raw)
  );

  assign neg1    = is_signed_div(op) && opa[XLEN-1];
  assign neg2    = is_signed_div(op) && opb[XLEN-1];
  assign quo_fix = (neg1 ^ neg2) ? -quo_raw : quo_raw;
  assign rem_fix = neg1 ? -rem_raw : rem_raw;
  assign div_res = div_special(op, opa, opb) ? div_special_res(op, opa, opb)
                                             : (op[1] ? rem_fix : quo_fix);

  // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MULH; low product bits ignore signedness.
  assign a_ext   = {{XLEN{(op != 2'b11) && opa[XLEN-1]}}, opa};
  assign b_ext   = {{XLEN{(op == 2'b01) && opb[XLEN-1]}}, opb};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
  logic special_in;
  assign special_in = div_special(func3[1:0], src1, src2);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      opa   <= '0;
      opb   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op  <= func3[1:0];
        opa <= src1;
        opb <= src2;
      end
    end
  end

  // result only moves on the edge into DONE, so it holds steady everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (!flush) begin
      if (state == MUL) begin
        result <= mul_res;
      end else if ((state == DIV) && div_last) begin
        result <= div_res;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (accept && func3[2] && special_in) begin
        result <= div_special_res(func3[1:0], src1, src2);
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    stall_req  = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start && !flush;
        if (start) begin
          if (!func3[2]) begin
            state_next = MUL;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (special_in) begin
            state_next = DONE;
          end
`endif
          else begin
            state_next = DIV;
          end
        end
      end
      MUL: begin
        busy       = 1'b1;
        stall_req  = 1'b1;
        state_next = DONE;
      end
      DIV: begin
        busy      = 1'b1;
        stall_req = 1'b1;
        if (div_last) state_next = DONE;
      end
      DONE: begin
        done       = !flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  func3;
  logic [31:0] src1, src2;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func3     (func3),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      F3_MUL:    begin p = sa * sb; return p[31:0];  end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
          return f[1] ? 32'(ia % ib) : 32'(ia / ib);
        end
        return f[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SP_LAT;
    return 33;
  endfunction

  // Cycle model: an op accepted in cycle t is in flight until cycle t+lat, where done pulses.
  bit          armed = 0;
  bit          act   = 0;
  int          done_cyc = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] held    = '0;

  always @(negedge clk) begin
    bit ed, eb, es;
    if (armed) begin
      ed = act && (cyc == done_cyc) && !flush;
      eb = act && (cyc < done_cyc);
      es = eb || (!act && start && !flush);
      chk("done", {31'b0, done}, {31'b0, ed});
      chk("busy", {31'b0, busy}, {31'b0, eb});
      chk("stall_req", {31'b0, stall_req}, {31'b0, es});
      chk("result", result, (act && cyc == done_cyc) ? exp_res : held);
    end
    if (rst) begin
      armed = 1;
      act   = 0;
      held  = '0;
    end else if (flush) begin
      act = 0;
    end else if (!act && start) begin
      act      = 1;
      done_cyc = cyc + model_lat(func3, src1, src2);
      exp_res  = model_res(func3, src1, src2);
    end else if (act && cyc == done_cyc) begin
      act  = 0;
      held = exp_res;
    end
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start = 1'b1;
    func3 = f;
    src1  = a;
    src2  = b;
  endtask

  // start stays high through DONE, as the pipeline would hold it, then drops.
  task automatic wait_done(input int t0, output int lat, output logic [31:0] res);
    bit got = 0;
    lat = -1;
    res = 'x;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        lat = cyc - t0;
        res = result;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [7:0]  lat;
  } vec_t;

  localparam logic [7:0] SPL = 8'(SP_LAT);

  vec_t vecs [0:19];

  initial begin
    int t0, t1, lat;
    logic [31:0] res;

    vecs = '{
      '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd2},
      '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33},
      '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33},
      '{F3_DIVU,   32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, SPL},
      '{F3_REMU,   32'h0000_0064, 32'h0000_0000, 32'h0000_0064, SPL},
      '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL},
      '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPL},
      '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd2},
      '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd2},
      '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd2},
      '{F3_MULHSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 8'd2},
      '{F3_MULH,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd2},
      '{F3_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 8'd33},
      '{F3_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 8'd33},
      '{F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 8'd33},
      '{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 8'd33},
      '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, SPL},
      '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, SPL},
      '{F3_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 8'd2},
      '{F3_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 8'd33}
    };

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = '0;
    src1  = '0;
    src2  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset stall_req", {31'b0, stall_req}, 32'd0);
    chk("reset result", result, 32'd0);

    foreach (vecs[i]) begin
      chk($sformatf("model vec%0d", i), model_res(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].res);
      launch(vecs[i].f, vecs[i].a, vecs[i].b);
      t0 = cyc;
      wait_done(t0, lat, res);
      chk($sformatf("vec%0d result", i), res, vecs[i].res);
      chk($sformatf("vec%0d latency", i), 32'(lat), {24'b0, vecs[i].lat});
    end

    // Flush in the 10th divide iteration, then a MULHU in the very next cycle.
    launch(F3_DIVU, 32'd100, 32'd3);
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    func3 = F3_MULHU;
    src1  = 32'hFFFF_FFFF;
    src2  = 32'hFFFF_FFFF;
    t1    = cyc;
    @(negedge clk);
    chk("flush idle busy", {31'b0, busy}, 32'd0);
    chk("flush idle stall_req", {31'b0, stall_req}, 32'd1);
    wait_done(t1, lat, res);
    chk("post-flush MULHU result", res, 32'hFFFF_FFFE);
    chk("post-flush MULHU latency", 32'(lat), 32'd2);

    // Reset in the 20th divide iteration; first op accepted straight after.
    launch(F3_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (20) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b1;
    func3 = F3_MUL;
    src1  = 32'd5;
    src2  = 32'd6;
    t1    = cyc;
    @(negedge clk);
    chk("mid-div reset busy", {31'b0, busy}, 32'd0);
    chk("mid-div reset done", {31'b0, done}, 32'd0);
    chk("mid-div reset result", result, 32'd0);
    wait_done(t1, lat, res);
    chk("after-reset MUL result", res, 32'd30);
    chk("after-reset MUL latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("start in DONE ignored", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected end of test before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
